// File: rtl/chimera_msip_ctrl.sv
// chimera_msip_ctrl: per-hart machine software interrupt (msip) source with a
// request/response register port, single-hart set/clear and a sequential
// range sweep that sets or clears a contiguous block of harts.
module chimera_msip_ctrl #(
    parameter int unsigned NumHarts  = 16,
    parameter int unsigned OffsWidth = 12
) (
    input  logic                 soc_clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [OffsWidth-1:0] req_offs_i,
    input  logic [31:0]          req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NumHarts-1:0]  msip_o
);

    localparam logic [OffsWidth-1:0] OFFS_SET  = OffsWidth'(32'h800);
    localparam logic [OffsWidth-1:0] OFFS_CLR  = OffsWidth'(32'h804);
    localparam logic [OffsWidth-1:0] OFFS_INFO = OffsWidth'(32'h808);
    localparam logic [9:0]           LAST_HART = 10'(NumHarts - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t              state_reg, state_next;
    logic [9:0]          ptr_reg, ptr_next;
    logic [9:0]          end_reg, end_next;
    logic                op_set_reg, op_set_next;
    // Last sweep write already done, response still waiting for the slot.
    logic                pend_reg, pend_next;
    logic [NumHarts-1:0] msip_reg, msip_next;

    logic                rsp_valid_reg;
    logic [31:0]         rsp_rdata_reg;
    logic                rsp_error_reg;
    logic                rsp_load;
    logic [31:0]         rsp_rdata_next;
    logic                rsp_error_next;

    // Address decode; the two low offset bits are don't-care.
    logic [OffsWidth-1:0] offs_al;
    logic [31:0]          word_idx;
    logic                 hit_msip, hit_set, hit_clr, hit_info, hit_any;
    logic [9:0]           lo_w, hi_w, hi_c;
    logic                 slot_free, accept, bcast_wr, start_sweep;
    logic                 single_we, sweep_we, rd_bit;
    logic                 unused_bits;

    assign offs_al  = {req_offs_i[OffsWidth-1:2], 2'b00};
    assign word_idx = 32'(req_offs_i[OffsWidth-1:2]);
    assign hit_msip = (32'(offs_al) < 32'h800) && (word_idx < NumHarts);
    assign hit_set  = (offs_al == OFFS_SET);
    assign hit_clr  = (offs_al == OFFS_CLR);
    assign hit_info = (offs_al == OFFS_INFO);
    assign hit_any  = hit_msip | hit_set | hit_clr | hit_info;

    // Range is clamped to the last implemented hart.
    assign lo_w = req_wdata_i[9:0];
    assign hi_w = req_wdata_i[25:16];
    assign hi_c = (32'(hi_w) > NumHarts - 1) ? LAST_HART : hi_w;

    // A response slot is free if empty or being drained on this edge.
    assign slot_free   = !rsp_valid_reg || rsp_ready_i;
    assign req_ready_o = (state_reg == IDLE) && slot_free;
    assign accept      = req_valid_i && req_ready_o;

    assign bcast_wr    = accept && req_write_i && (hit_set || hit_clr)
                         && req_wstrb_i[0] && req_wstrb_i[2];
    assign start_sweep = bcast_wr && (lo_w <= hi_c) && (32'(lo_w) < NumHarts);
    assign single_we   = accept && req_write_i && hit_msip && req_wstrb_i[0];
    assign sweep_we    = (state_reg == SWEEP) && !pend_reg;

    assign unused_bits = ^{req_offs_i[1:0], req_wdata_i[31:26], req_wdata_i[15:10],
                           req_wstrb_i[3], req_wstrb_i[1]};

    // Read mux for the addressed msip bit.
    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < int'(NumHarts); i++) begin
            if (word_idx == 32'(i)) rd_bit = msip_reg[i];
        end
    end

    // Per-hart next value: sweep write or single write, else hold.
    generate
        for (genvar gi = 0; gi < int'(NumHarts); gi++) begin : g_msip
            assign msip_next[gi] = (sweep_we && ptr_reg == 10'(gi)) ? op_set_reg :
                                   (single_we && word_idx == 32'(gi)) ? req_wdata_i[0] :
                                   msip_reg[gi];
        end
    endgenerate

    // Sweep FSM next-state: latch range on start, step ptr, finish at end.
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        end_next    = end_reg;
        op_set_next = op_set_reg;
        pend_next   = pend_reg;
        case (state_reg)
            IDLE: begin
                if (start_sweep) begin
                    state_next  = SWEEP;
                    ptr_next    = lo_w;
                    end_next    = hi_c;
                    op_set_next = hit_set;
                    pend_next   = 1'b0;
                end
            end
            SWEEP: begin
                if (ptr_reg == end_reg || pend_reg) begin
                    if (slot_free) begin
                        state_next = IDLE;
                        pend_next  = 1'b0;
                    end else begin
                        pend_next = 1'b1;
                    end
                end else begin
                    ptr_next = ptr_reg + 10'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response generation: immediate for plain accesses, deferred for sweeps.
    always_comb begin
        rsp_load       = 1'b0;
        rsp_rdata_next = 32'd0;
        rsp_error_next = 1'b0;
        if (state_reg == SWEEP) begin
            rsp_load = (ptr_reg == end_reg || pend_reg) && slot_free;
        end else if (accept && !start_sweep) begin
            rsp_load = 1'b1;
            if (!hit_any) begin
                rsp_error_next = 1'b1;
            end else if (!req_write_i) begin
                if (hit_msip)      rsp_rdata_next = {31'd0, rd_bit};
                else if (hit_info) rsp_rdata_next = {16'd0, 16'(NumHarts)};
            end
        end
    end

    // State, sweep context and msip registers.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            ptr_reg    <= 10'd0;
            end_reg    <= 10'd0;
            op_set_reg <= 1'b0;
            pend_reg   <= 1'b0;
            msip_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            end_reg    <= end_next;
            op_set_reg <= op_set_next;
            pend_reg   <= pend_next;
            msip_reg   <= msip_next;
        end
    end

    // Response register: load new, else drop valid on handshake, else hold.
    always_ff @(posedge soc_clk_i) begin
        if (rst_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_error_reg <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_error_reg <= rsp_error_next;
        end else if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_rdata_o = rsp_rdata_reg;
    assign rsp_error_o = rsp_error_reg;
    assign msip_o      = msip_reg;

endmodule

// File: tb/tb_chimera_msip_ctrl.sv
// Testbench for chimera_msip_ctrl: directed timing checks plus randomized
// traffic compared against a register-map model through a response scoreboard.
module tb_chimera_msip_ctrl;

    localparam int NH = 16;

    logic        soc_clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [11:0] req_offs_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic [NH-1:0] msip_o;

    chimera_msip_ctrl #(.NumHarts(NH), .OffsWidth(12)) dut (
        .soc_clk_i  (soc_clk_i),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_offs_i (req_offs_i),
        .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_error_o(rsp_error_o),
        .msip_o     (msip_o)
    );

    always #5 soc_clk_i = ~soc_clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] msip;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [15:0] model = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          bp_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Register-map model: applies the access to the msip image and returns
    // the response plus the msip image once the access has fully completed.
    function automatic exp_t predict(bit wr, logic [11:0] offs, logic [31:0] wd, logic [3:0] ws);
        exp_t e;
        int a = int'(offs) & 'hFFC;
        e.rdata = 0;
        e.err   = 0;
        if (a < 'h800) begin
            int h = a / 4;
            if (h < NH) begin
                if (wr) begin
                    if (ws[0]) model[h] = wd[0];
                end else begin
                    e.rdata = 32'(model[h]);
                end
            end else begin
                e.err = 1;
            end
        end else if (a == 'h800 || a == 'h804) begin
            if (wr && ws[0] && ws[2]) begin
                int lo = int'(wd[9:0]);
                int hi = int'(wd[25:16]);
                if (hi > NH - 1) hi = NH - 1;
                for (int h = lo; h <= hi; h++) model[h] = (a == 'h800);
            end
        end else if (a == 'h808) begin
            if (!wr) e.rdata = NH;
        end else begin
            e.err = 1;
        end
        e.msip = model;
        return e;
    endfunction

    // Push the expected response, then hold the request until accepted.
    // Returns 1 time unit after the accepting edge.
    task automatic issue(bit wr, logic [11:0] offs, logic [31:0] wd, logic [3:0] ws);
        int  waitc = 0;
        bit  acc = 0;
        sbq.push_back(predict(wr, offs, wd, ws));
        @(negedge soc_clk_i);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_offs_i  = offs;
        req_wdata_i = wd;
        req_wstrb_i = ws;
        while (!acc) begin
            acc = req_ready_o;
            @(posedge soc_clk_i);
            if (!acc) begin
                waitc++;
                if (waitc > 2000) begin
                    $display("FAIL issue_timeout: got ready=0 expected ready=1 within 2000 cycles");
                    $fatal(1, "request never accepted");
                end
                @(negedge soc_clk_i);
            end
        end
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((sbq.size() != 0 || !req_ready_o) && c < 3000) begin
            @(posedge soc_clk_i);
            #1;
            c++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    // Response-ready driver.
    always @(posedge soc_clk_i) begin
        #2;
        case (bp_mode)
            0:       rsp_ready_i = 1'b1;
            1:       rsp_ready_i = ($urandom_range(0, 3) != 0);
            default: rsp_ready_i = 1'b0;
        endcase
    end

    // Monitor: every completed response handshake is checked in order.
    always @(negedge soc_clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got rdata=0x%0h error=%0b expected no response",
                         rsp_rdata_o, rsp_error_o);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                chk("rsp_error", 32'(rsp_error_o), 32'(mon_e.err));
                chk("msip_at_rsp", 32'(msip_o), 32'(mon_e.msip));
            end
        end
    end

    initial begin
        logic [15:0] exp_m;
        int          bad;

        // Reset
        repeat (3) @(posedge soc_clk_i);
        @(negedge soc_clk_i);
        chk("reset_msip", 32'(msip_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("reset_rsp_error", 32'(rsp_error_o), 32'd0);
        rst_i = 1'b0;
        @(posedge soc_clk_i);
        #1;
        chk("ready_after_reset", 32'(req_ready_o), 32'd1);

        // Single write, readback, clear again
        issue(1, 12'h00C, 32'h1, 4'hF);
        chk("single_wr_msip", 32'(msip_o), 32'h0008);
        chk("single_wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        issue(0, 12'h00C, 32'h0, 4'hF);
        issue(1, 12'h00E, 32'h0, 4'hE);   // wstrb[0]=0: ignored
        issue(0, 12'h808, 32'h0, 4'hF);   // INFO
        issue(1, 12'h00C, 32'h0, 4'h1);
        wait_drain();

        // BCAST_SET lo=4 hi=11: one bit per cycle
        issue(1, 12'h800, 32'h000B_0004, 4'hF);
        chk("sweep_ready_low", 32'(req_ready_o), 32'd0);
        chk("sweep_start_msip", 32'(msip_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge soc_clk_i);
            #1;
            exp_m = 16'(((1 << (i + 1)) - 1) << 4);
            chk("sweep_set_msip", 32'(msip_o), 32'(exp_m));
            chk("sweep_rsp_valid", 32'(rsp_valid_o), (i == 7) ? 32'd1 : 32'd0);
            if (i < 7) chk("sweep_ready_low", 32'(req_ready_o), 32'd0);
        end
        wait_drain();

        // Fill all, then BCAST_CLR lo=2 hi=500 (clamps to 15)
        issue(1, 12'h800, 32'h000F_0000, 4'hF);
        wait_drain();
        chk("fill_all", 32'(msip_o), 32'hFFFF);
        issue(1, 12'h804, 32'h01F4_0002, 4'hF);
        for (int i = 1; i <= 14; i++) begin
            @(posedge soc_clk_i);
            #1;
            if (i == 13) begin
                chk("clr_clamp_m1_msip", 32'(msip_o), 32'h8003);
                chk("clr_clamp_m1_rsp", 32'(rsp_valid_o), 32'd0);
            end
            if (i == 14) begin
                chk("clr_clamp_msip", 32'(msip_o), 32'h0003);
                chk("clr_clamp_rsp", 32'(rsp_valid_o), 32'd1);
            end
        end
        wait_drain();

        // Degenerate sweep lo=9 hi=3
        issue(1, 12'h800, 32'h0003_0009, 4'hF);
        chk("degen_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("degen_msip", 32'(msip_o), 32'h0003);
        wait_drain();

        // Unmapped read with stalled response; a request is held meanwhile
        bp_mode = 2;
        issue(0, 12'h100, 32'h0, 4'hF);
        chk("unmapped_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("unmapped_error", 32'(rsp_error_o), 32'd1);
        chk("unmapped_rdata", rsp_rdata_o, 32'd0);
        @(negedge soc_clk_i);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_offs_i  = 12'h000;
        req_wdata_i = 32'h1;
        req_wstrb_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge soc_clk_i);
            #1;
            chk("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("stall_rsp_error", 32'(rsp_error_o), 32'd1);
            chk("stall_ready_low", 32'(req_ready_o), 32'd0);
            chk("stall_msip", 32'(msip_o), 32'h0003);
        end
        req_valid_i = 1'b0;
        bp_mode = 0;
        wait_drain();

        // Reset in the middle of a 0..15 sweep at ptr=6
        issue(1, 12'h804, 32'h000F_0000, 4'hF);
        wait_drain();
        issue(1, 12'h800, 32'h000F_0000, 4'hF);
        repeat (6) @(posedge soc_clk_i);
        #1;
        chk("pre_reset_msip", 32'(msip_o), 32'h003F);
        rst_i = 1'b1;
        sbq.delete();
        model = '0;
        @(posedge soc_clk_i);
        #1;
        chk("midreset_msip", 32'(msip_o), 32'd0);
        chk("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("midreset_idle", 32'(req_ready_o), 32'd1);
        @(negedge soc_clk_i);
        rst_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge soc_clk_i);
            #1;
            if (rsp_valid_o !== 1'b0 || msip_o !== '0) bad++;
        end
        chk("post_reset_quiet", 32'(bad), 32'd0);

        // Randomized traffic with random response back-pressure
        bp_mode = 1;
        for (int n = 0; n < 300; n++) begin
            int          r = $urandom_range(0, 9);
            bit          wr = 1'($urandom_range(0, 1));
            logic [11:0] offs;
            logic [31:0] wd = $urandom;
            logic [3:0]  ws = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (r <= 5) begin
                offs = 12'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            end else if (r <= 7) begin
                offs = 12'(($urandom_range(0, 1) ? 'h804 : 'h800) + $urandom_range(0, 3));
                wd = {6'd0, 10'($urandom_range(0, 40)), 6'd0, 10'($urandom_range(0, 20))};
            end else if (r == 8) begin
                offs = 12'h808;
            end else begin
                offs = 12'($urandom);
            end
            issue(wr, offs, wd, ws);
        end
        wait_drain();
        bp_mode = 0;
        wait_drain();
        chk("final_msip", 32'(msip_o), 32'(model));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
